// File: rtl/ni_packet_tx.sv
// Network-interface packetizer: turns a descriptor plus payload words into
// HEADER/BODY/TAIL flits for a router's local port under RTS/CTS flow control.
module ni_packet_tx #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] SRC_ADDR   = 4'b0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [3:0]            pkt_dst,
  input  logic [11:0]           pkt_len,
  input  logic                  pay_valid,
  output logic                  pay_ready,
  input  logic [27:0]           pay_data,
  output logic [DATA_WIDTH-1:0] TX,
  output logic                  RTS,
  input  logic                  DCTS,
  output logic                  busy,
  output logic                  err_len,
  output logic [15:0]           pkts_sent
);

  localparam logic [2:0] TYPE_HEADER = 3'b001;
  localparam logic [2:0] TYPE_BODY   = 3'b010;
  localparam logic [2:0] TYPE_TAIL   = 3'b100;

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t      state, next_state;
  logic        fv, free, load, hdr_load, err_next;
  logic [31:0] flit_q, next_flit;
  logic [11:0] rem, next_rem;
  logic [7:0]  seq_id;

  // Bit 0 is chosen so the XOR over the whole flit is zero.
  function automatic logic [31:0] with_parity(input logic [30:0] f);
    return {f, ^f};
  endfunction

  assign RTS  = fv && DCTS;
  assign free = !fv || RTS;
  assign TX   = flit_q;
  assign busy = (state == PAYLOAD) || fv;

  always_comb begin
    next_state = state;
    next_rem   = rem;
    next_flit  = flit_q;
    load       = 1'b0;
    hdr_load   = 1'b0;
    err_next   = 1'b0;
    pkt_ready  = 1'b0;
    pay_ready  = 1'b0;
    case (state)
      IDLE: begin
        pkt_ready = free && !rst;
        if (pkt_valid && pkt_ready) begin
          if (pkt_len >= 12'd2) begin
            load       = 1'b1;
            hdr_load   = 1'b1;
            next_flit  = with_parity({TYPE_HEADER, pkt_len, pkt_dst, SRC_ADDR, seq_id});
            next_rem   = pkt_len - 12'd1;
            next_state = PAYLOAD;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        pay_ready = free && !rst;
        if (pay_valid && pay_ready) begin
          load = 1'b1;
          if (rem > 12'd1) begin
            next_flit = with_parity({TYPE_BODY, pay_data});
            next_rem  = rem - 12'd1;
          end else begin
            next_flit  = with_parity({TYPE_TAIL, pay_data});
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A load and a transfer in the same cycle keep fv set, giving one flit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fv        <= 1'b0;
      flit_q    <= '0;
      rem       <= '0;
      seq_id    <= '0;
      err_len   <= 1'b0;
      pkts_sent <= '0;
    end else begin
      state   <= next_state;
      rem     <= next_rem;
      err_len <= err_next;
      if (load) begin
        flit_q <= next_flit;
        fv     <= 1'b1;
      end else if (RTS) begin
        fv <= 1'b0;
      end
      if (hdr_load)
        seq_id <= seq_id + 8'd1;
      if (RTS && flit_q[31:29] == TYPE_TAIL)
        pkts_sent <= pkts_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_ni_packet_tx.sv
// Bench for ni_packet_tx: directed packets, with a flit-queue model built from
// the packet descriptors and a per-cycle compare process on every transfer.
`timescale 1ns/1ps
module tb_ni_packet_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid, pkt_ready;
  logic [3:0]  pkt_dst;
  logic [11:0] pkt_len;
  logic        pay_valid, pay_ready;
  logic [27:0] pay_data;
  logic [31:0] TX;
  logic        RTS, DCTS, busy, err_len;
  logic [15:0] pkts_sent;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rtsCount = 0;
  bit modelOn = 1'b0;

  logic [31:0] expQ[$];
  logic [31:0] seen[$];
  logic [7:0]  hdrSeqs[$];
  int          rtsCycles[$];
  logic [7:0]  expSeq;
  logic [15:0] expSent;
  logic [27:0] payBuf[0:15];

  ni_packet_tx #(.DATA_WIDTH(32), .SRC_ADDR(4'b0000)) dut (
    .clk(clk), .rst(rst),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .TX(TX), .RTS(RTS), .DCTS(DCTS),
    .busy(busy), .err_len(err_len), .pkts_sent(pkts_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [31:0] expHeader(input logic [11:0] len, input logic [3:0] dst,
                                            input logic [7:0] seq);
    logic [30:0] b;
    b = {3'b001, len, dst, 4'b0000, seq};
    return {b, ^b};
  endfunction

  function automatic logic [31:0] expPay(input bit isTail, input logic [27:0] d);
    logic [30:0] b;
    b = {(isTail ? 3'b100 : 3'b010), d};
    return {b, ^b};
  endfunction

  // Every legal packet becomes a header plus len-1 payload flits, last one a tail.
  task automatic pushExpected(input logic [11:0] len, input logic [3:0] dst);
    if (len >= 12'd2) begin
      expQ.push_back(expHeader(len, dst, expSeq));
      expSeq++;
      for (int i = 1; i < int'(len); i++)
        expQ.push_back(expPay(i == int'(len) - 1, payBuf[i-1]));
      expSent++;
    end
  endtask

  task automatic driveDesc(input logic [11:0] len, input logic [3:0] dst);
    int g = 0;
    @(negedge clk);
    pay_valid = 1'b0;
    pkt_valid = 1'b1;
    pkt_len   = len;
    pkt_dst   = dst;
    #1;
    while (!pkt_ready && g < 100) begin @(negedge clk); #1; g++; end
    if (!pkt_ready) timeoutFail("desc_accept");
    @(posedge clk);
  endtask

  task automatic drivePay(input logic [27:0] d);
    int g = 0;
    @(negedge clk);
    pkt_valid = 1'b0;
    pay_valid = 1'b1;
    pay_data  = d;
    #1;
    while (!pay_ready && g < 100) begin @(negedge clk); #1; g++; end
    if (!pay_ready) timeoutFail("pay_accept");
    @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [11:0] len, input logic [3:0] dst);
    pushExpected(len, dst);
    driveDesc(len, dst);
    if (len >= 12'd2) begin
      for (int i = 1; i < int'(len); i++) drivePay(payBuf[i-1]);
    end else begin
      @(negedge clk);
      pkt_valid = 1'b0;
      #1;
      checkOutput("err_len_pulse", {31'd0, err_len}, 32'd1);
      checkOutput("busy_on_bad_len", {31'd0, busy}, 32'd0);
      @(negedge clk);
      #1;
      checkOutput("err_len_clear", {31'd0, err_len}, 32'd0);
    end
  endtask

  task automatic waitIdle();
    int g = 0;
    @(negedge clk);
    pkt_valid = 1'b0;
    pay_valid = 1'b0;
    #1;
    while (busy && g < 200) begin @(negedge clk); #1; g++; end
    if (busy) timeoutFail("drain");
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    pkt_valid = 1'b0;
    pay_valid = 1'b0;
    @(negedge clk);
    expQ.delete();
    expSeq  = '0;
    expSent = '0;
    rst = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_TX"}, TX, 32'd0);
    checkOutput({tag, "_RTS"}, {31'd0, RTS}, 32'd0);
    checkOutput({tag, "_pkt_ready"}, {31'd0, pkt_ready}, 32'd0);
    checkOutput({tag, "_pay_ready"}, {31'd0, pay_ready}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_err_len"}, {31'd0, err_len}, 32'd0);
    checkOutput({tag, "_pkts_sent"}, {16'd0, pkts_sent}, 32'd0);
  endtask

  // Each transfer must be the next flit the model expects, with even parity.
  always @(negedge clk) begin
    #1;
    if (modelOn && RTS) begin
      rtsCount++;
      rtsCycles.push_back(cyc);
      seen.push_back(TX);
      if (TX[31:29] == 3'b001) hdrSeqs.push_back(TX[8:1]);
      checkOutput("flit_parity", {31'd0, ^TX}, 32'd0);
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_flit: got %h expected none", TX);
      end else begin
        checkOutput("flit", TX, expQ.pop_front());
      end
    end
  end

  initial begin
    int n, r0, g;
    logic [31:0] saved;
    rst = 1'b1; pkt_valid = 1'b0; pay_valid = 1'b0; DCTS = 1'b1;
    pkt_len = '0; pkt_dst = '0; pay_data = '0;
    expSeq = '0; expSent = '0;
    for (int i = 0; i < 16; i++) payBuf[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    modelOn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", {31'd0, pkt_ready}, 32'd1);

    $display("[TB] basic 3-flit packet");
    payBuf[0] = 28'hABCDEF1; payBuf[1] = 28'h1234567;
    applyStimulus(12'd3, 4'h2);
    waitIdle();
    n = seen.size();
    checkOutput("t1_hdr_literal", seen[n-3], 32'h2006_4000);
    checkOutput("t1_body_literal", seen[n-2], 32'h5579_BDE3);
    checkOutput("t1_tail_literal", seen[n-1], 32'h8246_8ACF);
    checkOutput("t1_consecutive", 32'(rtsCycles[n-1] - rtsCycles[n-3]), 32'd2);
    checkOutput("t1_pkts_sent", {16'd0, pkts_sent}, {16'd0, expSent});

    $display("[TB] DCTS stall after header");
    r0 = rtsCount;
    fork
      applyStimulus(12'd3, 4'h2);
      begin
        g = 0;
        do begin @(negedge clk); #1; g++; end
        while (!(RTS && TX[31:29] == 3'b001) && g < 50);
        if (g >= 50) timeoutFail("stall_hdr_wait");
        else begin
          @(negedge clk);
          DCTS = 1'b0;
          #1;
          saved = TX;
          for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            checkOutput("stall_RTS", {31'd0, RTS}, 32'd0);
            checkOutput("stall_TX", TX, saved);
            checkOutput("stall_pay_ready", {31'd0, pay_ready}, 32'd0);
            checkOutput("stall_busy", {31'd0, busy}, 32'd1);
          end
          @(negedge clk);
          DCTS = 1'b1;
        end
      end
    join
    waitIdle();
    checkOutput("t2_flit_count", 32'(rtsCount - r0), 32'd3);
    checkOutput("t2_pkts_sent", {16'd0, pkts_sent}, {16'd0, expSent});

    $display("[TB] short and illegal lengths");
    payBuf[0] = 28'h5A5A5A5;
    applyStimulus(12'd2, 4'h7);
    waitIdle();
    r0 = rtsCount;
    applyStimulus(12'd1, 4'h3);
    applyStimulus(12'd0, 4'h3);
    checkOutput("no_flit_on_bad_len", 32'(rtsCount), 32'(r0));
    payBuf[0] = 28'h0F0F0F0;
    applyStimulus(12'd2, 4'h9);
    waitIdle();
    checkOutput("t3_pkts_sent", {16'd0, pkts_sent}, {16'd0, expSent});

    $display("[TB] back-to-back 4-flit packets");
    doReset();
    for (int i = 0; i < 3; i++) payBuf[i] = 28'h1000000 + 28'(i);
    applyStimulus(12'd4, 4'hA);
    applyStimulus(12'd4, 4'hB);
    waitIdle();
    n = rtsCycles.size();
    checkOutput("t4_no_bubble", 32'(rtsCycles[n-1] - rtsCycles[n-8]), 32'd7);
    n = hdrSeqs.size();
    checkOutput("t4_seq_first", {24'd0, hdrSeqs[n-2]}, 32'd0);
    checkOutput("t4_seq_second", {24'd0, hdrSeqs[n-1]}, 32'd1);

    $display("[TB] sequence and counter wrap");
    doReset();
    for (int i = 0; i < 257; i++) begin
      payBuf[0] = 28'(i * 3 + 1);
      applyStimulus(12'd2, 4'(i));
    end
    waitIdle();
    n = hdrSeqs.size();
    checkOutput("t5_seq_255", {24'd0, hdrSeqs[n-2]}, 32'h0000_00FF);
    checkOutput("t5_seq_wrap", {24'd0, hdrSeqs[n-1]}, 32'd0);
    checkOutput("t5_pkts_257", {16'd0, pkts_sent}, 32'd257);
    @(negedge clk);
    force dut.pkts_sent = 16'hFFFF;
    @(negedge clk);
    release dut.pkts_sent;
    #1;
    checkOutput("t5_preload", {16'd0, pkts_sent}, 32'h0000_FFFF);
    expSent = 16'hFFFF;
    payBuf[0] = 28'h7777777;
    applyStimulus(12'd2, 4'h1);
    waitIdle();
    checkOutput("t5_pkts_wrap", {16'd0, pkts_sent}, {16'd0, expSent});

    $display("[TB] reset mid-packet");
    doReset();
    for (int i = 0; i < 9; i++) payBuf[i] = 28'h0ABC000 + 28'(i);
    pushExpected(12'd10, 4'h5);
    driveDesc(12'd10, 4'h5);
    for (int i = 0; i < 3; i++) drivePay(payBuf[i]);
    @(negedge clk);
    rst = 1'b1;
    pkt_valid = 1'b0;
    pay_valid = 1'b0;
    @(negedge clk);
    expQ.delete();
    expSeq  = '0;
    expSent = '0;
    #1;
    checkResetOutputs("abort");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_ready", {31'd0, pkt_ready}, 32'd1);
    payBuf[0] = 28'h0000055; payBuf[1] = 28'h00000AA;
    applyStimulus(12'd3, 4'h4);
    waitIdle();
    n = hdrSeqs.size();
    checkOutput("abort_seq_restart", {24'd0, hdrSeqs[n-1]}, 32'd0);
    checkOutput("abort_pkts_sent", {16'd0, pkts_sent}, 32'd1);

    @(negedge clk);
    #1;
    checkOutput("model_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
